keypad_digit_entry: RTL
=======================

KEYPAD_DIGIT_ENTRY -- requirements
Module: keypad_digit_entry

Interface
REQ-001 Parameter: DB_CYCLES, default 4, consecutive identical samples required to accept a press or a release (legal range 2..15).
REQ-002 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: digit  input  4  binary digit code from the upstream 10-line priority encoder.
REQ-005 Port: valid  input  1  upstream "some key pressed" flag; may bounce and is asynchronous to any protocol.
REQ-006 Port: clear  input  1  synchronous clear of the entered number.
REQ-007 Port: number  output  16  four packed BCD digits; [3:0] holds the most recent digit.
REQ-008 Port: count  output  3  number of digits held, 0..4.
REQ-009 Port: full  output  1  high when count==4.
REQ-010 Port: key_strobe  output  1  one-cycle pulse when a digit is accepted.
REQ-011 Port: err  output  1  one-cycle pulse on a rejected press (digit>9, or press while full).
REQ-012 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, PRESS_DB, CAPTURE and REL_DB.
REQ-014 IDLE: valid=1 SHALL latch digit into cand, set db_cnt=1 and go to PRESS_DB; otherwise the FSM SHALL stay in IDLE.
REQ-015 PRESS_DB: valid=0 SHALL return the FSM to IDLE with db_cnt=0.
REQ-016 PRESS_DB: valid=1 with digit!=cand SHALL reload cand, set db_cnt=1 and stay in PRESS_DB.
REQ-017 PRESS_DB: valid=1 with digit==cand SHALL increment db_cnt; on the edge where db_cnt would reach DB_CYCLES the FSM SHALL go to CAPTURE.
REQ-018 CAPTURE SHALL last exactly one cycle and then go to REL_DB unconditionally.
REQ-019 CAPTURE with cand<=9 and count<4 SHALL, on its exit edge, shift number left by 4 ({number[11:0],cand}), increment count and pulse key_strobe for the following cycle.
REQ-020 CAPTURE with cand>9 or count==4 SHALL leave number and count unchanged and pulse err for the following cycle instead.
REQ-021 REL_DB: valid=0 SHALL increment db_cnt; valid=1 SHALL reset db_cnt to 0; when db_cnt reaches DB_CYCLES the FSM SHALL return to IDLE.
REQ-022 Holding a key in REL_DB SHALL never produce a second capture (no auto-repeat).
REQ-023 Latency: with a clean press whose valid is first sampled at edge k, number, count and key_strobe SHALL update at edge k+DB_CYCLES.
REQ-024 clear=1 SHALL zero number and count at the next edge without altering FSM state.
REQ-025 clear=1 coinciding with a CAPTURE exit edge SHALL take priority: number=0, count=0, no key_strobe, no err.
REQ-026 full SHALL be combinationally equal to (count==4).
REQ-027 key_strobe and err SHALL be registered and never both high in the same cycle.
REQ-028 db_cnt SHALL be 4 bits wide and saturate rather than wrap.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, number=16'h0000, count=0, full=0, key_strobe=0, err=0, busy=0, db_cnt=0 and cand=0, independent of clk.
REQ-030 rst_n asserted mid-debounce or mid-capture SHALL discard the pending press; after release, a fresh press SHALL be required.
REQ-031 Release of rst_n SHALL take effect at the first clk edge where it is sampled high; there is no other initialization.

Verification
REQ-032 Clean press: digit=7, valid=1 held 10 cycles, then valid=0 -> one key_strobe at edge k+4, number=16'h0007, count=1.
REQ-033 Bounce: valid toggles 1,0,1,0 then is steady at 1 with digit=3 -> exactly one capture, number=16'h0003.
REQ-034 Four presses 1,2,3,4 then a press of 5 -> number=16'h1234, full=1, err pulse on the fifth press, number unchanged.
REQ-035 Illegal code: digit=4'hC held as a valid press -> err pulse, count unchanged.
REQ-036 clear asserted in the CAPTURE cycle of a press of digit 9 -> number=0, count=0, no strobe.
REQ-037 rst_n dropped at db_cnt=2 -> all outputs zero at once; a subsequent clean press of digit 5 -> number=16'h0005, count=1.

Source files
------------

// File: rtl/keypad_digit_entry.sv
// keypad_digit_entry: debounces a priority-encoded keypad (valid + 4-bit
// digit), captures each accepted key once, and shifts it into a 4-digit
// packed BCD register. Codes above 9, or presses while four digits are
// already held, are rejected with a one-cycle err pulse instead.
//
// Handshake: there is no ready/back-pressure. valid is a raw, possibly
// bouncing level; a press is accepted only after DB_CYCLES consecutive
// identical valid samples, and the next press is armed only after
// DB_CYCLES consecutive released samples. key_strobe and err are
// registered single-cycle pulses that are never high together.
module keypad_digit_entry #(
    parameter int DB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  digit,
    input  logic        valid,
    input  logic        clear,
    output logic [15:0] number,
    output logic [2:0]  count,
    output logic        full,
    output logic        key_strobe,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PRESS_DB = 2'd1;
    localparam logic [1:0] S_CAPTURE  = 2'd2;
    localparam logic [1:0] S_REL_DB   = 2'd3;

    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES);

    logic [1:0]  r_state;
    logic [3:0]  r_db_cnt;
    logic [3:0]  r_cand;
    logic [15:0] r_number;
    logic [2:0]  r_count;
    logic        r_key_strobe;
    logic        r_err;

    logic [3:0]  w_db_inc;
    logic        w_capture;
    logic        w_accept;

    // Saturating increment of the debounce counter (never wraps to 0).
    assign w_db_inc  = (r_db_cnt == 4'hF) ? 4'hF : (r_db_cnt + 4'd1);
    assign w_capture = (r_state == S_CAPTURE);
    assign w_accept  = (r_cand <= 4'd9) && (r_count < 3'd4);

    // Debounce/capture FSM: track the candidate key and its stable-sample run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_db_cnt <= 4'd0;
            r_cand   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_cand   <= digit;
                        r_db_cnt <= 4'd1;
                        r_state  <= S_PRESS_DB;
                    end
                end
                S_PRESS_DB: begin
                    if (!valid) begin
                        r_db_cnt <= 4'd0;
                        r_state  <= S_IDLE;
                    end else if (digit != r_cand) begin
                        // A different key restarts the run with this sample.
                        r_cand   <= digit;
                        r_db_cnt <= 4'd1;
                    end else if (w_db_inc >= DB_LAST) begin
                        r_db_cnt <= 4'd0;
                        r_state  <= S_CAPTURE;
                    end else begin
                        r_db_cnt <= w_db_inc;
                    end
                end
                S_CAPTURE: begin
                    r_db_cnt <= 4'd0;
                    r_state  <= S_REL_DB;
                end
                default: begin
                    // Release debounce: any valid sample restarts the run, so a
                    // held key can never re-trigger a capture.
                    if (valid) begin
                        r_db_cnt <= 4'd0;
                    end else if (w_db_inc >= DB_LAST) begin
                        r_db_cnt <= 4'd0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_db_cnt <= w_db_inc;
                    end
                end
            endcase
        end
    end

    // Digit register, count and result pulses; clear overrides a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_number     <= 16'h0000;
            r_count      <= 3'd0;
            r_key_strobe <= 1'b0;
            r_err        <= 1'b0;
        end else if (clear) begin
            r_number     <= 16'h0000;
            r_count      <= 3'd0;
            r_key_strobe <= 1'b0;
            r_err        <= 1'b0;
        end else if (w_capture && w_accept) begin
            r_number     <= {r_number[11:0], r_cand};
            r_count      <= r_count + 3'd1;
            r_key_strobe <= 1'b1;
            r_err        <= 1'b0;
        end else if (w_capture) begin
            r_key_strobe <= 1'b0;
            r_err        <= 1'b1;
        end else begin
            r_key_strobe <= 1'b0;
            r_err        <= 1'b0;
        end
    end

    assign number     = r_number;
    assign count      = r_count;
    assign full       = (r_count == 3'd4);
    assign key_strobe = r_key_strobe;
    assign err        = r_err;
    assign busy       = (r_state != S_IDLE);

endmodule
